// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider, pixel/line counters, sync/visible decodes
// and a one-pixel-delayed registered pin stage for sync and colour.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned H_VIS_END   = 783,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned V_VIS_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_W   = 10'(H_SYNC);
  localparam logic [9:0] VS_W   = 10'(V_SYNC);
  localparam logic [9:0] HV_LO  = 10'(H_VIS_START);
  localparam logic [9:0] HV_HI  = 10'(H_VIS_END);
  localparam logic [9:0] VV_LO  = 10'(V_VIS_START);
  localparam logic [9:0] VV_HI  = 10'(V_VIS_END);

  logic [DW-1:0] div;
  logic          h_last, v_last, hsync_n, vsync_n;

  // Gated by rst so a held reset never shows a strobe, even before div clears.
  assign pix_en     = !rst && (div == DIV_LAST);
  assign h_last     = (hCount == H_LAST);
  assign v_last     = (vCount == V_LAST);
  assign frame_tick = pix_en && h_last && v_last;

  assign hsync_n = (hCount >= HS_W);
  assign vsync_n = (vCount >= VS_W);
  assign bright  = (hCount >= HV_LO) && (hCount <= HV_HI) &&
                   (vCount >= VV_LO) && (vCount <= VV_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      hCount <= '0;
      vCount <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (pix_en) begin
        vga_hs <= hsync_n;
        vga_vs <= vsync_n;
        {vga_r, vga_g, vga_b} <= bright ? rgb_in : 12'h000;
        if (h_last) begin
          hCount <= '0;
          vCount <= v_last ? '0 : vCount + 10'd1;
        end else begin
          hCount <= hCount + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster so whole frames fit
// in a short run; expected values come from the raster geometry below.
module tb_vga_timing_gen;

  localparam int CD = 4, HT = 20, VT = 12, HS = 3, VS = 2;
  localparam int HVS = 5, HVE = 14, VVS = 3, VVE = 9;
  localparam int FRAME = CD * HT * VT;  // 960 clk per frame

  logic        clk, rst;
  logic [11:0] rgb_in;
  logic [9:0]  hCount, vCount;
  logic        bright, pix_en, frame_tick, vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;

  int vecs = 0;
  int errs = 0;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
    .H_VIS_START(HVS), .H_VIS_END(HVE), .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .hCount(hCount), .vCount(vCount),
    .bright(bright), .pix_en(pix_en), .frame_tick(frame_tick),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Pixel colour is red on strobe cycles and junk otherwise; junk must never land.
  initial begin
    rgb_in = 12'hF00;
    forever begin
      @(negedge clk);
      rgb_in = pix_en ? 12'hF00 : 12'($urandom);
    end
  end

  function automatic bit vis(int h, int v);
    return (h >= HVS) && (h <= HVE) && (v >= VVS) && (v <= VVE);
  endfunction

  task automatic wait_pos(input int h, input int v, input bit need_pe, input string nm);
    int n = 0;
    while (!(hCount == 10'(h) && vCount == 10'(v) && (!need_pe || pix_en)) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * FRAME) begin
      errs++;
      $display("FAIL %s: timeout waiting for (%0d,%0d), at (%0d,%0d)", nm, h, v, hCount, vCount);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if ({hCount, vCount, vga_hs, vga_vs, vga_r, vga_g, vga_b, pix_en, frame_tick}
          !== {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL reset[%0d]: h=%0d v=%0d hs=%b vs=%b rgb=%h pe=%b ft=%b, want 0 0 1 1 000 0 0",
                 i, hCount, vCount, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, pix_en, frame_tick);
      end
    end
    rst = 0;  // current cycle is now cycle 1
  endtask

  task automatic test_divider();
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      vecs++;
      if (pix_en !== ((k % 4) == 0) || hCount !== 10'((k - 1) / 4) || frame_tick !== 1'b0) begin
        errs++;
        $display("FAIL divider cycle %0d: pe=%b h=%0d ft=%b, want pe=%b h=%0d ft=0",
                 k, pix_en, hCount, frame_tick, (k % 4) == 0, (k - 1) / 4);
      end
    end
  endtask

  task automatic test_line_wrap();
    wait_pos(HT - 1, 4, 1, "line_wrap");
    @(negedge clk);
    vecs++;
    if (hCount !== 10'd0 || vCount !== 10'd5 || vga_hs !== 1'b1) begin
      errs++;
      $display("FAIL line_wrap: h=%0d v=%0d hs=%b, want 0 5 1", hCount, vCount, vga_hs);
    end
    wait_pos(HS, 5, 0, "hs_low");
    vecs++;
    if (vga_hs !== 1'b0) begin
      errs++;
      $display("FAIL hs_lag_low: vga_hs=%b at h=%0d, want 0", vga_hs, hCount);
    end
    wait_pos(HS + 1, 5, 0, "hs_high");
    vecs++;
    if (vga_hs !== 1'b1) begin
      errs++;
      $display("FAIL hs_lag_high: vga_hs=%b at h=%0d, want 1", vga_hs, hCount);
    end
  endtask

  task automatic test_frame_wrap();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (frame_tick !== 1'b1 || hCount !== 10'(HT - 1) || vCount !== 10'(VT - 1) || pix_en !== 1'b1) begin
      errs++;
      $display("FAIL frame_tick_pos: ft=%b h=%0d v=%0d pe=%b, want 1 %0d %0d 1",
               frame_tick, hCount, vCount, pix_en, HT - 1, VT - 1);
    end
    @(negedge clk);
    vecs++;
    if (hCount !== 10'd0 || vCount !== 10'd0 || frame_tick !== 1'b0 || vga_vs !== 1'b1) begin
      errs++;
      $display("FAIL frame_wrap: h=%0d v=%0d ft=%b vs=%b, want 0 0 0 1", hCount, vCount, frame_tick, vga_vs);
    end
    n = 1;
    while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n !== FRAME) begin
      errs++;
      $display("FAIL frame_period: %0d clk between ticks, want %0d", n, FRAME);
    end
  endtask

  task automatic test_bright_colour();
    int tab_h[8] = '{HVS - 1, HVS, HVE, HVE + 1, 8, 8, 8, 8};
    int tab_v[8] = '{5, 5, 5, 5, VVS - 1, VVS, VVE, VVE + 1};
    bit tab_b[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      wait_pos(tab_h[i], tab_v[i], 0, "bright_pos");
      vecs++;
      if (bright !== tab_b[i]) begin
        errs++;
        $display("FAIL bright(%0d,%0d): %b, want %b", tab_h[i], tab_v[i], bright, tab_b[i]);
      end
      wait_pos(tab_h[i] + 1, tab_v[i], 0, "colour_pos");
      vecs++;
      if (vga_r !== (tab_b[i] ? 4'hF : 4'h0) || vga_g !== 4'h0 || vga_b !== 4'h0) begin
        errs++;
        $display("FAIL colour(%0d,%0d): rgb=%h%h%h, want %h00",
                 tab_h[i], tab_v[i], vga_r, vga_g, vga_b, tab_b[i] ? 4'hF : 4'h0);
      end
    end
  endtask

  // Reset mid-frame, then follow more than a full frame cycle by cycle.
  task automatic test_mid_frame_reset();
    int mh = 0, mv = 0, first_tick = 0;
    bit mhs = 1, mvs = 1, pe;
    logic [3:0] mr = 4'h0;
    wait_pos(10, 6, 0, "mid_reset_pos");
    rst = 1;
    @(negedge clk);
    vecs++;
    if ({hCount, vCount, pix_en, frame_tick, vga_hs, vga_vs, vga_r} !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0}) begin
      errs++;
      $display("FAIL mid_reset: h=%0d v=%0d pe=%b ft=%b hs=%b vs=%b r=%h, want 0 0 0 0 1 1 0",
               hCount, vCount, pix_en, frame_tick, vga_hs, vga_vs, vga_r);
    end
    rst = 0;
    for (int k = 1; k <= FRAME + 100; k++) begin
      if (k > 1) @(negedge clk);
      pe = (k % CD) == 0;
      vecs++;
      if (hCount !== 10'(mh) || vCount !== 10'(mv) || pix_en !== pe ||
          frame_tick !== (pe && mh == HT - 1 && mv == VT - 1) || bright !== vis(mh, mv) ||
          vga_hs !== mhs || vga_vs !== mvs || vga_r !== mr || vga_g !== 4'h0 || vga_b !== 4'h0) begin
        errs++;
        $display("FAIL run cycle %0d: h=%0d v=%0d pe=%b ft=%b br=%b hs=%b vs=%b rgb=%h%h%h, want h=%0d v=%0d pe=%b hs=%b vs=%b r=%h",
                 k, hCount, vCount, pix_en, frame_tick, bright, vga_hs, vga_vs, vga_r, vga_g, vga_b,
                 mh, mv, pe, mhs, mvs, mr);
      end
      if (frame_tick === 1'b1 && first_tick == 0) first_tick = k;
      if (pe) begin
        mhs = mh >= HS;
        mvs = mv >= VS;
        mr  = vis(mh, mv) ? 4'hF : 4'h0;
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
    end
    vecs++;
    if (first_tick !== FRAME) begin
      errs++;
      $display("FAIL tick_after_reset: first tick at cycle %0d, want %0d", first_tick, FRAME);
    end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_divider();
    test_line_wrap();
    test_frame_wrap();
    test_bright_colour();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
